handshake_transmitter: RTL and testbench



---
 rtl/handshake_transmitter.sv | 152 +++++++++++++++
 tb/tb_handshake_transmitter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_transmitter.sv
// Serial transmitter for the handshake wire: sends SYNCWORD then one latched packet, MSB first.
// Optional continuous retransmission with idle gap is enabled by defining HS_TX_REPEAT_EN.

package NetworkPkg;
    localparam int               SYNC_BITS     = 8;
    localparam logic [7:0]       SYNCWORD      = 8'hA5;
    localparam int               ENC_HEAD_BITS = 16;
endpackage

module handshake_transmitter #(
    parameter int                   SYNC_BITS = NetworkPkg::SYNC_BITS,
    parameter logic [SYNC_BITS-1:0] SYNCWORD  = NetworkPkg::SYNCWORD,
    parameter int                   DATA_BITS = NetworkPkg::ENC_HEAD_BITS,
    parameter int                   GAP_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 send_start,
    input  logic                 game_active,
    input  logic                 repeat_en,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 send_done
);

    localparam int MAX_SD  = (SYNC_BITS > DATA_BITS) ? SYNC_BITS : DATA_BITS;
    localparam int MAX_ALL = (MAX_SD > GAP_BITS) ? MAX_SD : GAP_BITS;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
`ifdef HS_TX_REPEAT_EN
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        DONE = 3'd3
`ifdef HS_TX_REPEAT_EN
        , GAP = 3'd4
`endif
    } state_t;

    state_t                state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [DATA_BITS-1:0]  data_sr_r;
    logic [SYNC_BITS-1:0]  sync_sr_r;

    // Transmit FSM; the output register always holds the bit for the current line cycle.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            data_sr_r  <= '0;
            sync_sr_r  <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            send_done  <= 1'b0;
        end else if (!game_active) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            send_done  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (send_start) begin
                        data_sr_r  <= data_in;
                        sync_sr_r  <= SYNCWORD;
                        cnt_r      <= CNT_ZERO;
                        serial_out <= SYNCWORD[SYNC_BITS-1];
                        busy       <= 1'b1;
                        send_done  <= 1'b0;
                        state_r    <= SYNC;
                    end else begin
                        serial_out <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                SYNC: begin
                    if (cnt_r == SYNC_LAST) begin
                        serial_out <= data_sr_r[DATA_BITS-1];
                        cnt_r      <= CNT_ZERO;
                        state_r    <= DATA;
                    end else begin
                        // MSB is already on the line, so the next bit is one below it.
                        serial_out <= sync_sr_r[SYNC_BITS-2];
                        sync_sr_r  <= {sync_sr_r[SYNC_BITS-2:0], 1'b0};
                        cnt_r      <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    // Rotate rather than shift so the packet survives for a repeat.
                    data_sr_r <= {data_sr_r[DATA_BITS-2:0], data_sr_r[DATA_BITS-1]};
                    if (cnt_r == DATA_LAST) begin
                        cnt_r      <= CNT_ZERO;
                        serial_out <= 1'b0;
                        send_done  <= 1'b1;
`ifdef HS_TX_REPEAT_EN
                        if (repeat_en) begin
                            state_r <= GAP;
                        end else begin
                            busy    <= 1'b0;
                            state_r <= DONE;
                        end
`else
                        busy    <= 1'b0;
                        state_r <= DONE;
`endif
                    end else begin
                        serial_out <= data_sr_r[DATA_BITS-2];
                        cnt_r      <= cnt_r + CNT_ONE;
                    end
                end
`ifdef HS_TX_REPEAT_EN
                GAP: begin
                    serial_out <= 1'b0;
                    send_done  <= 1'b0;
                    if (cnt_r == GAP_LAST) begin
                        cnt_r <= CNT_ZERO;
                        if (repeat_en) begin
                            sync_sr_r  <= SYNCWORD;
                            serial_out <= SYNCWORD[SYNC_BITS-1];
                            state_r    <= SYNC;
                        end else begin
                            busy      <= 1'b0;
                            send_done <= 1'b1;
                            state_r   <= DONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
`endif
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= CNT_ZERO;
                    serial_out <= 1'b0;
                    busy       <= 1'b0;
                    send_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_transmitter.sv
// Scoreboard bench for handshake_transmitter; the repeat scenario runs when HS_TX_REPEAT_EN is defined.
`timescale 1ns/1ps
module tb_handshake_transmitter;

    localparam int         SB = 8;
    localparam int         DB = 16;
    localparam int         GB = 4;
    localparam logic [7:0] SW = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        send_start = 1'b0;
    logic        game_active = 1'b0;
    logic        repeat_en = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic        serial_out;
    logic        busy;
    logic        send_done;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    handshake_transmitter #(
        .SYNC_BITS (SB),
        .SYNCWORD  (SW),
        .DATA_BITS (DB),
        .GAP_BITS  (GB)
    ) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .send_start  (send_start),
        .game_active (game_active),
        .repeat_en   (repeat_en),
        .data_in     (data_in),
        .serial_out  (serial_out),
        .busy        (busy),
        .send_done   (send_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_packet(input logic [15:0] d);
        logic [7:0] sw;
        sw = SW;
        for (int i = SB - 1; i >= 0; i--) exp_q.push_back(sw[i]);
        for (int i = DB - 1; i >= 0; i--) exp_q.push_back(d[i]);
    endtask

    task automatic start_packet(input logic [15:0] d);
        data_in    = d;
        send_start = 1'b1;
        tick;
        send_start = 1'b0;
        push_packet(d);
    endtask

    // Pops n_bits expected line bits; optionally injects a stray start at bit inject_at.
    task automatic check_packet(input string tag, input logic [15:0] d, input int n_bits, input int inject_at);
        logic [15:0] rx;
        logic        e;
        rx = 16'h0000;
        for (int i = 0; i < n_bits; i++) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL %s bit%0d: scoreboard empty", tag, i);
                break;
            end
            e = exp_q.pop_front();
            if (serial_out !== e || busy !== 1'b1 || send_done !== 1'b0) begin
                n_err++;
                $display("FAIL %s bit%0d: serial_out/busy/send_done=%b/%b/%b required %b/1/0",
                         tag, i, serial_out, busy, send_done, e);
            end
            if (i >= SB) rx = {rx[14:0], serial_out};
            if (i == inject_at) begin
                send_start = 1'b1;
                data_in    = 16'h1234;
            end
            tick;
            send_start = 1'b0;
        end
        if (n_bits == SB + DB) begin
            n_cmp++;
            if (rx !== d) begin
                n_err++;
                $display("FAIL %s loopback: got %h required %h", tag, rx, d);
            end
        end
    endtask

    task automatic check_outs(input string tag, input logic s, input logic b, input logic dn);
        n_cmp++;
        if (serial_out !== s || busy !== b || send_done !== dn) begin
            n_err++;
            $display("FAIL %s: serial_out/busy/send_done=%b/%b/%b required %b/%b/%b",
                     tag, serial_out, busy, send_done, s, b, dn);
        end
    endtask

    task automatic test_reset;
        game_active = 1'b1;
        tick;
        tick;
        check_outs("reset_held", 1'b0, 1'b0, 1'b0);
        rst_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check_outs("idle_after_reset", 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_packets;
        logic [15:0] pats [4];
        pats = '{16'hBEEF, 16'h0000, 16'hFFFF, 16'h5A3C};
`ifndef HS_TX_REPEAT_EN
        repeat_en = 1'b1;
`endif
        for (int p = 0; p < 4; p++) begin
            start_packet(pats[p]);
            check_packet("packet", pats[p], SB + DB, -1);
            check_outs("done_entry", 1'b0, 1'b0, 1'b1);
            tick;
            tick;
            check_outs("done_held", 1'b0, 1'b0, 1'b1);
        end
        repeat_en = 1'b0;
    endtask

    task automatic test_ignore_start;
        start_packet(16'hBEEF);
        check_packet("ignore_start", 16'hBEEF, SB + DB, 9);
        check_outs("ignore_done", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        start_packet(16'hC3A5);
        check_packet("back_to_back", 16'hC3A5, SB + DB, -1);
        check_outs("b2b_done", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_abort;
        start_packet(16'hBEEF);
        check_packet("abort_partial", 16'hBEEF, 14, -1);
        game_active = 1'b0;
        tick;
        game_active = 1'b1;
        exp_q.delete();
        check_outs("abort_next", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) tick;
        check_outs("abort_idle", 1'b0, 1'b0, 1'b0);
        start_packet(16'h1234);
        check_packet("after_abort", 16'h1234, SB + DB, -1);
        check_outs("after_abort_done", 1'b0, 1'b0, 1'b1);
        send_start  = 1'b1;
        game_active = 1'b0;
        tick;
        send_start  = 1'b0;
        game_active = 1'b1;
        check_outs("abort_priority", 1'b0, 1'b0, 1'b0);
        tick;
        check_outs("abort_priority_idle", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset;
        start_packet(16'hBEEF);
        check_packet("pre_reset", 16'hBEEF, 4, -1);
        #1;
        rst_l = 1'b0;
        #1;
        exp_q.delete();
        check_outs("async_reset", 1'b0, 1'b0, 1'b0);
        tick;
        rst_l = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        check_outs("post_reset_idle", 1'b0, 1'b0, 1'b0);
    endtask

`ifdef HS_TX_REPEAT_EN
    task automatic test_repeat;
        repeat_en = 1'b1;
        start_packet(16'hBEEF);
        check_packet("repeat_first", 16'hBEEF, SB + DB, -1);
        check_outs("gap_pulse", 1'b0, 1'b1, 1'b1);
        tick;
        for (int i = 1; i < GB; i++) begin
            check_outs("gap_zero", 1'b0, 1'b1, 1'b0);
            tick;
        end
        push_packet(16'hBEEF);
        repeat_en = 1'b0;
        check_packet("repeat_second", 16'hBEEF, SB + DB, -1);
        check_outs("repeat_done", 1'b0, 1'b0, 1'b1);
        tick;
        tick;
        check_outs("repeat_done_held", 1'b0, 1'b0, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_packets();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_async_reset();
`ifdef HS_TX_REPEAT_EN
        test_repeat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
